score_seg_display: RTL
======================

Name: score_seg_display

Overview:
- Downstream consumer of the snake game top's score and team outputs: score, current_team, team1_score, team2_score, game_complete.
- Drives a 4-digit multiplexed common-anode 7-segment display.
- During play it shows the active team's live score. After both teams finish, it alternates between the two final scores.
- Binary-to-BCD conversion is a sequential shift-add-3 (double-dabble) engine, one shift per clock.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz digit rate at 100 MHz).
- ALT_DIV, 200000000: clk cycles per team alternation when game_complete=1 (2 s at 100 MHz).

Ports:
- clk  in  1  system clock, the same clock as the game top.
- rst  in  1  synchronous, active-high reset.
- score  in  8  live score of the current team, binary 0..255.
- current_team  in  2  1 = team 1, 2 = team 2; 0 and 3 are shown as blank.
- team1_score  in  8  latched final score of team 1.
- team2_score  in  8  latched final score of team 2.
- game_complete  in  1  both teams have played.
- an  out  4  digit enables, active-low; an[3] is the leftmost digit.
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low. Lit only on digit 3 while game_complete=1.
- bcd_valid  out  1  high when the displayed BCD matches the currently selected source value.

Behaviour:
- Reset values (synchronous, active-high, rst sampled on the clk edge):
  - an=4'b1111, seg=7'h7F, dp=1, bcd_valid=0.
  - BCD register = 0; scan counter, digit index, alternation counter and alternation select all = 0.
  - Converter FSM in IDLE.
- Source select:
  - game_complete=0: value=score, team digit=current_team.
  - game_complete=1: alt_sel chooses team1_score/"1" or team2_score/"2".
  - alt_sel toggles every ALT_DIV cycles and is cleared on the cycle game_complete falls.
- Converter FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: if value != last_conv (an 8-bit register, reset 0) or the first-run flag is set, latch value into last_conv and the shift register, clear the 12-bit BCD accumulator, go to SHIFT. Set the first-run flag on reset so that 0 still converts.
  - SHIFT: 8 cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left by 1 with the next binary MSB entering. Go to DONE after the 8th shift.
  - DONE: copy the accumulator to the display BCD register atomically, then return to IDLE.
- Latency: value change to display update is 10 clocks (1 load + 8 shifts + 1 commit).
- bcd_valid:
  - Low from the cycle any value change is detected until the DONE cycle.
  - High from the cycle after DONE, provided value still equals last_conv.
- Input change mid-conversion: the conversion is not aborted. It finishes with the old value, commits, then restarts next cycle; bcd_valid stays low throughout. The display never shows a partial result.
- Scan:
  - The counter counts 0..SCAN_DIV-1. At wrap, the digit index increments modulo 4.
  - Exactly one an bit is low at a time, index 0 → an[0].
- Digit content:
  - Digit 3: team digit glyph ("1" or "2"), or blank.
  - Digit 2: hundreds, blanked if 0.
  - Digit 1: tens, blanked if hundreds and tens are both 0.
  - Digit 0: ones, always shown.
- Registered outputs: an, seg and dp are registered and change together on the scan edge, with no cross-digit ghost cycle. Segment data for the new index is computed from the registered BCD.
- Blank glyph: seg=7'h7F.

Decomposition:
- Shared package (seg_display_pkg):
  - 7-segment glyph constants 0–9 and SEG_BLANK.
  - Converter state encoding: IDLE, SHIFT, DONE.
  - TEAM_1 / TEAM_2 codes matching the game top's team encoding.
- Sub-module: bin2bcd_seq, the 8-bit to 3-digit sequential double-dabble.
  - Ports: clk, rst, start, bin[7:0], busy, done, bcd[11:0].
  - The parent handles source muxing, change detection, commit, scan and glyphs.

Test Plan:
- Reset then release with score=0, current_team=1:
  - After 10 clocks bcd_valid=1.
  - Scan shows digit 3="1", digits 2 and 1 blank, digit 0="0"; an cycles 1110→1101→1011→0111, SCAN_DIV clocks per slot.
- score steps 0→255:
  - bcd_valid falls on the next edge and rises exactly 10 clocks later.
  - Digits read 2,5,5, with seg for "5"=7'h12.
- score 9→10 mid-conversion, then 10→99 on conversion cycle 4:
  - 10 commits, then 99 commits 10 clocks after that.
  - No intermediate BCD other than 010/099 is ever displayed.
- score=7:
  - Hundreds and tens are blank; ones shows "7".
  - score=100 shows "1","0","0" with no blanking.
- game_complete=1, team1_score=42, team2_score=188, ALT_DIV=16 for sim:
  - Display alternates "1 42"/"2188" every 16 clocks, each change followed by re-conversion. dp is low on digit 3 only.
- Assert rst mid-SHIFT and mid-scan:
  - Next cycle an=1111, seg=7'h7F, bcd_valid=0, FSM in IDLE.
  - After release, conversion of the current value completes within 10 clocks.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared definitions for the score display: glyphs, converter states, team codes
// and the double-dabble nibble adjust step.
package seg_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_e;

  localparam logic [1:0] TEAM_1 = 2'd1;
  localparam logic [1:0] TEAM_2 = 2'd2;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

  function automatic logic [11:0] dd_adjust(input logic [11:0] acc);
    logic [11:0] res;
    for (int i = 0; i < 3; i++) begin
      res[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? acc[i*4 +: 4] + 4'd3 : acc[i*4 +: 4];
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit to 3-digit BCD converter: load on start, eight shift-add-3
// steps, then one DONE cycle in which bcd holds the finished result.
module bin2bcd_seq
  import seg_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  step_q, step_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (step_q == 3'd7) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_comb begin
    shift_d = shift_q;
    acc_d   = acc_q;
    step_d  = step_q;
    if (state_q == StIdle && start) begin
      shift_d = bin;
      acc_d   = '0;
      step_d  = '0;
    end else if (state_q == StShift) begin
      // Adjust before shifting so every nibble stays a legal BCD digit
      {acc_d, shift_d} = {dd_adjust(acc_q), shift_q} << 1;
      step_d           = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      acc_q   <= '0;
      step_q  <= '0;
    end else begin
      shift_q <= shift_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
    end
  end

  assign bcd = acc_q;

endmodule

// File: rtl/score_seg_display.sv
// Four-digit multiplexed score display: team glyph plus a leading-zero-blanked
// 3-digit score, alternating between final team scores once the game is over.
module score_seg_display
  import seg_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned ALT_DIV  = 200000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] score,
  input  logic [1:0] current_team,
  input  logic [7:0] team1_score,
  input  logic [7:0] team2_score,
  input  logic       game_complete,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       bcd_valid
);

  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned AltW  = (ALT_DIV > 1) ? $clog2(ALT_DIV) : 1;

  logic [7:0]       value;
  logic [1:0]       team;
  logic             conv_start, conv_busy, conv_done;
  logic [11:0]      conv_bcd;

  logic [7:0]       last_conv_q, last_conv_d;
  logic             first_run_q, first_run_d;
  logic [11:0]      disp_bcd_q, disp_bcd_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [AltW-1:0]  alt_cnt_q, alt_cnt_d;
  logic             alt_sel_q, alt_sel_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       hund, tens, ones;

  always_comb begin
    if (game_complete) begin
      value = alt_sel_q ? team2_score : team1_score;
      team  = alt_sel_q ? TEAM_2 : TEAM_1;
    end else begin
      value = score;
      team  = current_team;
    end
  end

  assign conv_start = !conv_busy && ((value != last_conv_q) || first_run_q);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Display BCD only moves on DONE, so a partial result is never visible
  always_comb begin
    last_conv_d = last_conv_q;
    first_run_d = first_run_q;
    disp_bcd_d  = disp_bcd_q;
    bcd_valid_d = bcd_valid_q;
    if (conv_start) begin
      last_conv_d = value;
      first_run_d = 1'b0;
      bcd_valid_d = 1'b0;
    end else if (conv_done) begin
      disp_bcd_d  = conv_bcd;
      bcd_valid_d = (value == last_conv_q);
    end
  end

  always_comb begin
    alt_cnt_d = alt_cnt_q;
    alt_sel_d = alt_sel_q;
    if (!game_complete) begin
      alt_cnt_d = '0;
      alt_sel_d = 1'b0;
    end else if (alt_cnt_q == AltW'(ALT_DIV - 1)) begin
      alt_cnt_d = '0;
      alt_sel_d = !alt_sel_q;
    end else begin
      alt_cnt_d = alt_cnt_q + AltW'(1);
    end
  end

  always_comb begin
    if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end else begin
      scan_cnt_d  = scan_cnt_q + ScanW'(1);
      digit_idx_d = digit_idx_q;
    end
  end

  assign hund = disp_bcd_q[11:8];
  assign tens = disp_bcd_q[7:4];
  assign ones = disp_bcd_q[3:0];

  // Outputs are built from the next digit index so an/seg/dp switch together
  always_comb begin
    an_d = ~(4'b0001 << digit_idx_d);
    dp_d = !((digit_idx_d == 2'd3) && game_complete);
    case (digit_idx_d)
      2'd3: begin
        if (team == TEAM_1)      seg_d = SEG_1;
        else if (team == TEAM_2) seg_d = SEG_2;
        else                     seg_d = SEG_BLANK;
      end
      2'd2:    seg_d = (hund == 4'd0) ? SEG_BLANK : seg_glyph(hund);
      2'd1:    seg_d = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_glyph(tens);
      default: seg_d = seg_glyph(ones);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_conv_q <= '0;
      first_run_q <= 1'b1;
      disp_bcd_q  <= '0;
      bcd_valid_q <= 1'b0;
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      alt_cnt_q   <= '0;
      alt_sel_q   <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      last_conv_q <= last_conv_d;
      first_run_q <= first_run_d;
      disp_bcd_q  <= disp_bcd_d;
      bcd_valid_q <= bcd_valid_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      alt_cnt_q   <= alt_cnt_d;
      alt_sel_q   <= alt_sel_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign bcd_valid = bcd_valid_q;

endmodule
